// File: rtl/icache_fill_arb_pkg.sv
// Shared types, constants and nibble-order helpers for the icache fill / data port arbiter.
package icache_fill_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    XFER   = 3'd2,
    REPLAY = 3'd3,
    ACK    = 3'd4
  } state_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_D  = 1'b1
  } req_t;

  localparam int FILL_NIBBLES = 8;
  localparam int LEN_BYTE     = 1;
  localparam int LEN_HALF     = 3;

  // Buffer nibble k sits at bits [4k+3:4k]; on the wire each byte goes high nibble first.
  function automatic logic [31:0] store_pack(input logic [15:0] wdata);
    return {16'h0000, wdata[11:8], wdata[15:12], wdata[3:0], wdata[7:4]};
  endfunction

  function automatic logic [15:0] load_assemble(input logic [15:0] word, input logic size);
    logic [7:0] byte0;
    logic [7:0] byte1;
    byte0 = {word[3:0], word[7:4]};
    byte1 = {word[11:8], word[15:12]};
    return size ? {byte1, byte0} : {8'h00, byte0};
  endfunction

endpackage

// File: rtl/icache_fill_arb_if.sv
// Nibble-serial memory controller port: command, read nibble stream and write nibble stream.
interface icache_fill_arb_if #(
  parameter int PA = 22
) ();
  logic          mem_req;
  logic [PA-1:0] mem_addr;
  logic          mem_we;
  logic [2:0]    mem_len;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [3:0]    mem_rdata;
  logic          mem_wready;
  logic [3:0]    mem_wdata;
  logic          mem_done;

  modport master (
    output mem_req, mem_addr, mem_we, mem_len, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_wready, mem_done
  );

  modport slave (
    input  mem_req, mem_addr, mem_we, mem_len, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata, mem_wready, mem_done
  );
endinterface

// File: rtl/icache_fill_arb_nibble_sreg.sv
// 32-bit nibble buffer: whole-word load, single-nibble write by index, look-ahead read by index.
module nibble_sreg (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_en,
  input  logic [31:0] load_word,
  input  logic        wr_en,
  input  logic [2:0]  wr_idx,
  input  logic [3:0]  wr_nib,
  input  logic [2:0]  rd_idx,
  output logic [3:0]  rd_nib,
  output logic [15:0] word_lo
);

  logic [31:0] word_r;
  logic [31:0] word_nx_s;

  // Reads see the value being written this cycle so a nibble arriving with mem_done is not lost.
  always_comb begin
    word_nx_s = word_r;
    if (load_en) begin
      word_nx_s = load_word;
    end else if (wr_en) begin
      word_nx_s[{wr_idx, 2'b00} +: 4] = wr_nib;
    end else begin
      word_nx_s = word_r;
    end
  end

  assign rd_nib  = word_nx_s[{rd_idx, 2'b00} +: 4];
  assign word_lo = word_nx_s[15:0];

  // Buffer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_r <= 32'h0000_0000;
    end else begin
      word_r <= word_nx_s;
    end
  end

endmodule

// File: rtl/icache_fill_arb.sv
// Arbitrates one nibble-serial memory port between icache line fills and CPU loads/stores,
// and replays each collected fill line to the icache as 8 gapless nibble strobes.
module icache_fill_arb
  import icache_fill_pkg::*;
#(
  parameter int PA          = 22,
  parameter int LINE_LENGTH = 4,
  parameter int RV          = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ic_pull,
  input  logic [PA-3:0] ic_tag,
  input  logic          flush_all,
  output logic [3:0]    ic_dread,
  output logic          ic_wstrobe_d,
  output logic          ic_busy,
  input  logic          d_req,
  input  logic [PA-1:0] d_addr,
  input  logic          d_we,
  input  logic          d_size,
  input  logic [RV-1:0] d_wdata,
  output logic          d_ack,
  output logic [RV-1:0] d_rdata,
  icache_fill_arb_if.master mem
);

  localparam logic [2:0] LEN_FILL = 3'(2 * LINE_LENGTH - 1);

  state_t        state_r, state_n;
  req_t          req_r, req_n, rr_last_r, rr_last_n, pick_s;
  logic          start_s, stale_s, in_range_s;
  logic [PA-1:0] addr_r, addr_n;
  logic [PA-3:0] tag_r, tag_n;
  logic [2:0]    len_r, len_n;
  logic          we_r, we_n, size_r, size_n, discard_r, discard_n;
  logic [3:0]    cnt_r, cnt_n;

  logic          load_en_s, wr_en_s;
  logic [31:0]   load_word_s;
  logic [3:0]    rd_nib_s;
  logic [15:0]   word_lo_s;

  logic [3:0]    ic_dread_r, ic_dread_n, mem_wdata_r, mem_wdata_n;
  logic          ic_wstrobe_r, ic_wstrobe_n, ic_busy_r, ic_busy_n;
  logic          d_ack_r, d_ack_n, mem_req_r, mem_req_n;
  logic [RV-1:0] d_rdata_r, d_rdata_n;

  nibble_sreg u_sreg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_en   (load_en_s),
    .load_word (load_word_s),
    .wr_en     (wr_en_s),
    .wr_idx    (cnt_r[2:0]),
    .wr_nib    (mem.mem_rdata),
    .rd_idx    (cnt_n[2:0]),
    .rd_nib    (rd_nib_s),
    .word_lo   (word_lo_s)
  );

  assign stale_s    = discard_r | flush_all | (ic_tag != tag_r);
  assign in_range_s = (cnt_r <= {1'b0, len_r});

  // Round-robin pick between the two requesters; only consulted in IDLE.
  always_comb begin
    start_s = 1'b1;
    pick_s  = REQ_IC;
    if (ic_pull && d_req) begin
      pick_s = (rr_last_r == REQ_IC) ? REQ_D : REQ_IC;
    end else if (ic_pull) begin
      pick_s = REQ_IC;
    end else if (d_req) begin
      pick_s = REQ_D;
    end else begin
      start_s = 1'b0;
    end
  end

  // Next state, latched command fields and next values of the registered outputs.
  always_comb begin
    state_n     = state_r;
    req_n       = req_r;
    rr_last_n   = rr_last_r;
    addr_n      = addr_r;
    tag_n       = tag_r;
    len_n       = len_r;
    we_n        = we_r;
    size_n      = size_r;
    discard_n   = discard_r;
    cnt_n       = cnt_r;
    load_en_s   = 1'b0;
    load_word_s = 32'h0000_0000;
    wr_en_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_n   = CMD;
          req_n     = pick_s;
          rr_last_n = pick_s;
          discard_n = 1'b0;
          cnt_n     = 4'd0;
          load_en_s = 1'b1;
          if (pick_s == REQ_IC) begin
            addr_n = {ic_tag, 2'b00};
            tag_n  = ic_tag;
            len_n  = LEN_FILL;
            we_n   = 1'b0;
            size_n = 1'b0;
          end else begin
            addr_n      = d_addr;
            len_n       = d_size ? 3'(LEN_HALF) : 3'(LEN_BYTE);
            we_n        = d_we;
            size_n      = d_size;
            load_word_s = d_we ? store_pack(d_wdata) : 32'h0000_0000;
          end
        end else begin
          state_n = IDLE;
        end
      end
      CMD: begin
        if (req_r == REQ_IC && flush_all) begin
          discard_n = 1'b1;
        end else begin
          discard_n = discard_r;
        end
        if (mem.mem_gnt) begin
          state_n = XFER;
          cnt_n   = 4'd0;
        end else begin
          state_n = CMD;
        end
      end
      XFER: begin
        if (req_r == REQ_IC && flush_all) begin
          discard_n = 1'b1;
        end else begin
          discard_n = discard_r;
        end
        if (we_r) begin
          if (mem.mem_wready && in_range_s) begin
            cnt_n = cnt_r + 4'd1;
          end else begin
            cnt_n = cnt_r;
          end
        end else begin
          if (mem.mem_rvalid && in_range_s) begin
            wr_en_s = 1'b1;
            cnt_n   = cnt_r + 4'd1;
          end else begin
            cnt_n = cnt_r;
          end
        end
        // A short transfer still completes: unwritten nibbles stay at their cleared value.
        if (mem.mem_done) begin
          if (req_r == REQ_D) begin
            state_n = ACK;
          end else if (stale_s) begin
            state_n = IDLE;
          end else begin
            state_n = REPLAY;
            cnt_n   = 4'd0;
          end
        end else begin
          state_n = XFER;
        end
      end
      REPLAY: begin
        if (cnt_r == 4'(FILL_NIBBLES - 1)) begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end else begin
          state_n = REPLAY;
          cnt_n   = cnt_r + 4'd1;
        end
      end
      ACK: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    mem_req_n    = (state_n == CMD);
    ic_wstrobe_n = (state_n == REPLAY);
    ic_dread_n   = (state_n == REPLAY) ? rd_nib_s : 4'h0;
    ic_busy_n    = (req_n == REQ_IC) && (state_n inside {CMD, XFER, REPLAY});
    d_ack_n      = (state_n == ACK);
    d_rdata_n    = (state_n == ACK && !we_n) ? load_assemble(word_lo_s, size_n) : 16'h0000;
    mem_wdata_n  = (state_n == XFER && we_n) ? rd_nib_s : 4'h0;
  end

  // State, command and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      req_r        <= REQ_IC;
      rr_last_r    <= REQ_D;
      addr_r       <= {PA{1'b0}};
      tag_r        <= {(PA-2){1'b0}};
      len_r        <= 3'd0;
      we_r         <= 1'b0;
      size_r       <= 1'b0;
      discard_r    <= 1'b0;
      cnt_r        <= 4'd0;
      mem_req_r    <= 1'b0;
      mem_wdata_r  <= 4'h0;
      ic_wstrobe_r <= 1'b0;
      ic_dread_r   <= 4'h0;
      ic_busy_r    <= 1'b0;
      d_ack_r      <= 1'b0;
      d_rdata_r    <= {RV{1'b0}};
    end else begin
      state_r      <= state_n;
      req_r        <= req_n;
      rr_last_r    <= rr_last_n;
      addr_r       <= addr_n;
      tag_r        <= tag_n;
      len_r        <= len_n;
      we_r         <= we_n;
      size_r       <= size_n;
      discard_r    <= discard_n;
      cnt_r        <= cnt_n;
      mem_req_r    <= mem_req_n;
      mem_wdata_r  <= mem_wdata_n;
      ic_wstrobe_r <= ic_wstrobe_n;
      ic_dread_r   <= ic_dread_n;
      ic_busy_r    <= ic_busy_n;
      d_ack_r      <= d_ack_n;
      d_rdata_r    <= d_rdata_n;
    end
  end

  assign mem.mem_req   = mem_req_r;
  assign mem.mem_addr  = addr_r;
  assign mem.mem_we    = we_r;
  assign mem.mem_len   = len_r;
  assign mem.mem_wdata = mem_wdata_r;
  assign ic_wstrobe_d  = ic_wstrobe_r;
  assign ic_dread      = ic_dread_r;
  assign ic_busy       = ic_busy_r;
  assign d_ack         = d_ack_r;
  assign d_rdata       = d_rdata_r;

endmodule
